// File: rtl/flash_ctrl_pkg.sv
// rtl/flash_ctrl_pkg.sv - shared constants and period helper for the LED flash rate controller
package flash_ctrl_pkg;

   localparam int KEY_SLOW = 0;
   localparam int KEY_FAST = 1;
   localparam int KEY_DFLT = 2;
   localparam int NUM_KEYS = 3;

   localparam int LEVEL_W = 4;
   localparam logic [LEVEL_W-1:0] MIN_LEVEL = 4'd1;

   function automatic logic [31:0] level_period(input logic [LEVEL_W-1:0] lvl,
                                                input logic [31:0]         step);
      return 32'(lvl) * step;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser plus stability counter for one active-low push key;
// emits single-cycle press (1->0) and release (0->1) pulses when the accepted state flips.
module key_debounce #(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_state,
   output logic press_ev,
   output logic release_ev
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   logic          sync_a;
   logic          sync_b;
   logic [CW-1:0] db_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a     <= 1'b1;
         sync_b     <= 1'b1;
         key_state  <= 1'b1;
         db_cnt     <= '0;
         press_ev   <= 1'b0;
         release_ev <= 1'b0;
      end else begin
         sync_a     <= key_raw;
         sync_b     <= sync_a;
         press_ev   <= 1'b0;
         release_ev <= 1'b0;
         // Count only while the synchronised key disagrees with the accepted state.
         if (sync_b == key_state) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            key_state  <= sync_b;
            db_cnt     <= '0;
            press_ev   <= key_state;
            release_ev <= ~key_state;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/flash_rate_ctrl.sv
// rtl/flash_rate_ctrl.sv - key-driven speed level, flash period and tick generator for the LED flasher.
// Optional held-key auto-repeat is built when FLASH_AUTO_REPEAT_EN is defined.
module flash_rate_ctrl
   import flash_ctrl_pkg::*;
#(
   parameter int DB_CYCLES     = 500000,
   parameter int STEP_CYCLES   = 12500000,
   parameter int MAX_LEVEL     = 8,
   parameter int DEFAULT_LEVEL = 2,
   parameter int REPEAT_CYCLES = 25000000
) (
   input  logic               CLOCK_50,
   input  logic               RESET,
   input  logic [2:0]         KEY,
   output logic [LEVEL_W-1:0] level,
   output logic [31:0]        period,
   output logic               tick,
   output logic               level_chg
);

   localparam logic [LEVEL_W-1:0] MAX_LVL  = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0] DFLT_LVL = LEVEL_W'(DEFAULT_LEVEL);
   localparam logic [31:0]        STEP     = 32'(STEP_CYCLES);

   if (64'(MAX_LEVEL) * 64'(STEP_CYCLES) >= 64'h1_0000_0000) begin : g_period_overflow
      $error("MAX_LEVEL*STEP_CYCLES does not fit in 32 bits");
   end
   if (MAX_LEVEL >= (1 << LEVEL_W) || DEFAULT_LEVEL < 1 || DEFAULT_LEVEL > MAX_LEVEL) begin : g_level_range
      $error("DEFAULT_LEVEL/MAX_LEVEL out of range");
   end
   if (DB_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_cycle_range
      $error("DB_CYCLES and REPEAT_CYCLES must be at least 1");
   end

   logic [NUM_KEYS-1:0] key_state;
   logic [NUM_KEYS-1:0] press_ev;
   logic [NUM_KEYS-1:0] release_ev;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce #(
         .DB_CYCLES (DB_CYCLES)
      ) u_db (
         .clk        (CLOCK_50),
         .rst        (RESET),
         .key_raw    (KEY[k]),
         .key_state  (key_state[k]),
         .press_ev   (press_ev[k]),
         .release_ev (release_ev[k])
      );
   end

   logic [1:0] rep_fire;
   logic [1:0] rep_done;
   logic       unused_ev;

`ifdef FLASH_AUTO_REPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   for (genvar r = 0; r < 2; r++) begin : g_rep
      logic [RW-1:0] rep_cnt;
      logic          done;

      assign rep_fire[r] = ~key_state[r] && (rep_cnt == REP_LAST);
      assign rep_done[r] = done;

      // done remembers that this hold already stepped, so its release is swallowed.
      always_ff @(posedge CLOCK_50 or posedge RESET) begin
         if (RESET) begin
            rep_cnt <= '0;
            done    <= 1'b0;
         end else begin
            if (key_state[r] || rep_fire[r]) begin
               rep_cnt <= '0;
            end else begin
               rep_cnt <= rep_cnt + 1'b1;
            end
            if (rep_fire[r]) begin
               done <= 1'b1;
            end else if (press_ev[r]) begin
               done <= 1'b0;
            end
         end
      end
   end

   assign unused_ev = release_ev[KEY_DFLT];
`else
   assign rep_fire  = 2'b00;
   assign rep_done  = 2'b00;
   assign unused_ev = release_ev[KEY_DFLT] | press_ev[KEY_SLOW] | press_ev[KEY_FAST];
`endif

   logic               step_up;
   logic               step_dn;
   logic [LEVEL_W-1:0] lvl_next;
   logic               chg;

   assign step_up = rep_fire[KEY_SLOW] | (release_ev[KEY_SLOW] & ~rep_done[KEY_SLOW]);
   assign step_dn = rep_fire[KEY_FAST] | (release_ev[KEY_FAST] & ~rep_done[KEY_FAST]);

   // Default press wins; slow-down beats speed-up; steps are ignored while the default key is held.
   always_comb begin
      lvl_next = level;
      if (press_ev[KEY_DFLT]) begin
         lvl_next = DFLT_LVL;
      end else if (key_state[KEY_DFLT]) begin
         if (step_up) begin
            if (level < MAX_LVL) lvl_next = level + 1'b1;
         end else if (step_dn) begin
            if (level > MIN_LEVEL) lvl_next = level - 1'b1;
         end
      end
      chg = (lvl_next != level);
   end

   logic [31:0] tick_cnt;

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         level     <= DFLT_LVL;
         period    <= level_period(DFLT_LVL, STEP);
         level_chg <= 1'b0;
         tick_cnt  <= '0;
      end else begin
         level     <= lvl_next;
         level_chg <= chg;
         if (chg) period <= level_period(lvl_next, STEP);
         if (level_chg || tick_cnt >= period - 32'd1) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + 32'd1;
         end
      end
   end

   assign tick = ~level_chg && (tick_cnt == period - 32'd1);

endmodule

// File: tb/tb_flash_rate_ctrl.sv
// tb/tb_flash_rate_ctrl.sv - directed self-checking bench for flash_rate_ctrl
`timescale 1ns/1ps
module tb_flash_rate_ctrl;

   logic        CLOCK_50;
   logic        RESET;
   logic [2:0]  KEY;
   logic [3:0]  level;
   logic [31:0] period;
   logic        tick;
   logic        level_chg;

   int checks = 0;
   int errors = 0;
   int chg_cnt = 0;

   flash_rate_ctrl #(
      .DB_CYCLES     (4),
      .STEP_CYCLES   (10),
      .MAX_LEVEL     (8),
      .DEFAULT_LEVEL (2),
      .REPEAT_CYCLES (30)
   ) dut (
      .CLOCK_50  (CLOCK_50),
      .RESET     (RESET),
      .KEY       (KEY),
      .level     (level),
      .period    (period),
      .tick      (tick),
      .level_chg (level_chg)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   always @(negedge CLOCK_50) if (level_chg === 1'b1) chg_cnt++;

   task automatic do_reset();
      @(negedge CLOCK_50);
      RESET = 1'b1;
      KEY   = 3'b111;
      repeat (2) @(negedge CLOCK_50);
      RESET = 1'b0;
      repeat (2) @(negedge CLOCK_50);
   endtask

   task automatic key_pulse(input int k, input int low_n, input int high_n);
      @(negedge CLOCK_50);
      KEY[k] = 1'b0;
      repeat (low_n) @(negedge CLOCK_50);
      KEY[k] = 1'b1;
      repeat (high_n) @(negedge CLOCK_50);
   endtask

   task automatic wait_chg(input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLOCK_50);
         if (level_chg === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit exp_t;
      RESET = 1'b1;
      KEY   = 3'b111;
      repeat (3) @(negedge CLOCK_50);
      checks++; if (level !== 4'd2) begin errors++; $display("FAIL reset_level got %0d want 2", level); end
      checks++; if (period !== 32'd20) begin errors++; $display("FAIL reset_period got %0d want 20", period); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
      checks++; if (level_chg !== 1'b0) begin errors++; $display("FAIL reset_chg got %b want 0", level_chg); end
      RESET = 1'b0;
      for (int k = 0; k < 100; k++) begin
         exp_t = (k % 20 == 19);
         checks++;
         if (tick !== exp_t) begin errors++; $display("FAIL reset_tick_cycle%0d got %b want %b", k, tick, exp_t); end
         @(negedge CLOCK_50);
      end
   endtask

   task automatic test_step();
      bit found;
      int c0;
      int j;
      c0 = chg_cnt;
      @(negedge CLOCK_50);
      KEY[0] = 1'b0;
      repeat (10) @(negedge CLOCK_50);
      KEY[0] = 1'b1;
      wait_chg(20, found);
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL step_chg_seen got %b want 1", found); end
      checks++; if (level !== 4'd3) begin errors++; $display("FAIL step_level got %0d want 3", level); end
      checks++; if (period !== 32'd30) begin errors++; $display("FAIL step_period got %0d want 30", period); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL step_tick_suppressed got %b want 0", tick); end
      j = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge CLOCK_50);
         if (tick === 1'b1) begin
            j = i;
            break;
         end
      end
      checks++; if (j != 30) begin errors++; $display("FAIL step_first_tick got %0d want 30", j); end
      key_pulse(0, 2, 20);
      checks++; if (level !== 4'd3) begin errors++; $display("FAIL glitch_level got %0d want 3", level); end
      checks++; if (chg_cnt - c0 != 1) begin errors++; $display("FAIL glitch_chg_count got %0d want 1", chg_cnt - c0); end
   endtask

   task automatic test_saturate();
      int c0;
      int t0;
      int j;
      do_reset();
      c0 = chg_cnt;
      for (int n = 0; n < 7; n++) key_pulse(0, 8, 10);
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL sat_hi_level got %0d want 8", level); end
      checks++; if (period !== 32'd80) begin errors++; $display("FAIL sat_hi_period got %0d want 80", period); end
      checks++; if (chg_cnt - c0 != 6) begin errors++; $display("FAIL sat_hi_chg got %0d want 6", chg_cnt - c0); end
      c0 = chg_cnt;
      for (int n = 0; n < 8; n++) key_pulse(1, 8, 10);
      checks++; if (level !== 4'd1) begin errors++; $display("FAIL sat_lo_level got %0d want 1", level); end
      checks++; if (period !== 32'd10) begin errors++; $display("FAIL sat_lo_period got %0d want 10", period); end
      checks++; if (chg_cnt - c0 != 7) begin errors++; $display("FAIL sat_lo_chg got %0d want 7", chg_cnt - c0); end
      t0 = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge CLOCK_50);
         if (tick === 1'b1) begin
            t0 = i;
            break;
         end
      end
      j = 0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge CLOCK_50);
         if (tick === 1'b1) begin
            j = i;
            break;
         end
      end
      checks++; if (t0 == 0 || j != 10) begin errors++; $display("FAIL sat_lo_tick_interval got %0d want 10", j); end
   endtask

   task automatic test_priority();
      int c0;
      do_reset();
      for (int n = 0; n < 3; n++) key_pulse(0, 8, 10);
      checks++; if (level !== 4'd5) begin errors++; $display("FAIL prio_setup_level got %0d want 5", level); end
      c0 = chg_cnt;
      @(negedge CLOCK_50);
      KEY[0] = 1'b0;
      repeat (10) @(negedge CLOCK_50);
      KEY = 3'b011;
      repeat (10) @(negedge CLOCK_50);
      checks++; if (level !== 4'd2) begin errors++; $display("FAIL prio_dflt_wins got %0d want 2", level); end
      checks++; if (chg_cnt - c0 != 1) begin errors++; $display("FAIL prio_dflt_chg got %0d want 1", chg_cnt - c0); end
      key_pulse(0, 8, 10);
      checks++; if (level !== 4'd2) begin errors++; $display("FAIL prio_step_while_dflt got %0d want 2", level); end
      KEY[2] = 1'b1;
      repeat (10) @(negedge CLOCK_50);
      c0 = chg_cnt;
      key_pulse(2, 8, 10);
      checks++; if (chg_cnt - c0 != 0) begin errors++; $display("FAIL prio_dflt_nochange_chg got %0d want 0", chg_cnt - c0); end
      key_pulse(0, 8, 10);
      checks++; if (level !== 4'd3) begin errors++; $display("FAIL prio_setup3 got %0d want 3", level); end
      @(negedge CLOCK_50);
      KEY = 3'b100;
      repeat (10) @(negedge CLOCK_50);
      KEY = 3'b111;
      repeat (10) @(negedge CLOCK_50);
      checks++; if (level !== 4'd4) begin errors++; $display("FAIL prio_slow_beats_fast got %0d want 4", level); end
   endtask

   task automatic test_reset_mid();
      bit found;
      int c0;
      do_reset();
      @(negedge CLOCK_50);
      KEY[0] = 1'b0;
      repeat (8) @(negedge CLOCK_50);
      KEY[0] = 1'b1;
      wait_chg(20, found);
      checks++; if (found !== 1'b1 || level !== 4'd3) begin errors++; $display("FAIL rmid_setup got %0d want 3", level); end
      repeat (5) @(negedge CLOCK_50);
      KEY[1] = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      RESET = 1'b1;
      #1;
      checks++; if (level !== 4'd2) begin errors++; $display("FAIL rmid_level got %0d want 2", level); end
      checks++; if (period !== 32'd20) begin errors++; $display("FAIL rmid_period got %0d want 20", period); end
      checks++; if (tick !== 1'b0 || level_chg !== 1'b0) begin errors++; $display("FAIL rmid_pulses got %b%b want 00", tick, level_chg); end
      repeat (2) @(negedge CLOCK_50);
      RESET = 1'b0;
      c0 = chg_cnt;
      repeat (2) @(negedge CLOCK_50);
      KEY[1] = 1'b1;
      repeat (30) @(negedge CLOCK_50);
      checks++; if (level !== 4'd2) begin errors++; $display("FAIL rmid_no_step got %0d want 2", level); end
      checks++; if (chg_cnt - c0 != 0) begin errors++; $display("FAIL rmid_no_chg got %0d want 0", chg_cnt - c0); end
   endtask

   task automatic test_auto_repeat();
      int c0;
      int exp_lvl;
      int exp_chg;
`ifdef FLASH_AUTO_REPEAT_EN
      exp_lvl = 5;
      exp_chg = 3;
`else
      exp_lvl = 3;
      exp_chg = 1;
`endif
      do_reset();
      c0 = chg_cnt;
      @(negedge CLOCK_50);
      KEY[0] = 1'b0;
      repeat (100) @(negedge CLOCK_50);
      KEY[0] = 1'b1;
      repeat (20) @(negedge CLOCK_50);
      checks++; if (level !== 4'(exp_lvl)) begin errors++; $display("FAIL hold_level got %0d want %0d", level, exp_lvl); end
      checks++; if (chg_cnt - c0 != exp_chg) begin errors++; $display("FAIL hold_chg got %0d want %0d", chg_cnt - c0, exp_chg); end
      checks++; if (period !== 32'(exp_lvl * 10)) begin errors++; $display("FAIL hold_period got %0d want %0d", period, exp_lvl * 10); end
   endtask

   initial begin
      RESET = 1'b1;
      KEY   = 3'b111;
      test_reset();
      test_step();
      test_saturate();
      test_priority();
      test_reset_mid();
      test_auto_repeat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
